// File: rtl/regfile_pkg.sv
// Shared constants and commit-FSM state encoding for the register-file
// write queue.
package regfile_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    localparam logic RF_READ  = 1'b0;
    localparam logic RF_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } commit_state_e;

endpackage

// File: rtl/regfile_wq_fifo.sv
// Circular buffer of pending register writes. Every slot is exposed together
// with a valid bit so the read side can search all pending entries.
module regfile_wq_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [AW-1:0]            push_addr,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [AW-1:0]            head_addr,
    output logic [DW-1:0]            head_data,
    output logic [$clog2(DEPTH)-1:0] head_ptr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [AW-1:0]            entry_addr [DEPTH],
    output logic [DW-1:0]            entry_data [DEPTH],
    output logic [DEPTH-1:0]         entry_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers are exactly PW bits wide, so DEPTH being a power of two
    // makes the modulo-DEPTH wrap free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    assign head_addr  = mem_addr[rd_ptr];
    assign head_data  = mem_data[rd_ptr];
    assign head_ptr   = rd_ptr;
    assign full       = (count == CW'(DEPTH));
    assign entry_addr = mem_addr;
    assign entry_data = mem_data;

    // A slot is live when its distance from the head is below count.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = ({1'b0, PW'(i) - rd_ptr} < count);
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// Write-side front end for the register file: queues writes, commits each as
// a setup/strobe/hold sequence and forwards pending data to the read port.
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = regfile_pkg::AW,
    parameter int DW    = regfile_pkg::DW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [AW-1:0]          wr_addr,
    input  logic [DW-1:0]          wr_data,
    output logic                   rf_mode,
    output logic [AW-1:0]          rf_waddr,
    output logic [DW-1:0]          rf_wdata,
    input  logic [AW-1:0]          rd_addr,
    output logic [AW-1:0]          rf_raddr,
    input  logic [DW-1:0]          rf_rdata,
    output logic [DW-1:0]          rd_data,
    output logic                   rd_hit,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    import regfile_pkg::*;

    localparam int PW = $clog2(DEPTH);

    commit_state_e state;
    logic          push;
    logic          pop;
    logic          full;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic [PW-1:0] head_ptr;
    logic [AW-1:0] entry_addr [DEPTH];
    logic [DW-1:0] entry_data [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic [PW-1:0] fwd_idx;

    // Handshake: a write transfers on a rising edge where wr_valid && wr_ready;
    // wr_ready depends only on registered occupancy, never on wr_valid or a pop.
    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign pop      = (state == STROBE);
    assign empty    = (count == '0) && (state == IDLE);
    assign rf_raddr = rd_addr;

    regfile_wq_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_addr   (wr_addr),
        .push_data   (wr_data),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .head_ptr    (head_ptr),
        .count       (count),
        .full        (full),
        .entry_addr  (entry_addr),
        .entry_data  (entry_data),
        .entry_valid (entry_valid)
    );

    // Address/data only move on entry to SETUP, so they are stable across
    // the whole strobe and the hold phase that follows it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rf_mode  <= RF_READ;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state    <= SETUP;
                        rf_waddr <= head_addr;
                        rf_wdata <= head_data;
                    end
                end
                SETUP: begin
                    state   <= STROBE;
                    rf_mode <= RF_WRITE;
                end
                STROBE: begin
                    state   <= HOLD;
                    rf_mode <= RF_READ;
                end
                HOLD: begin
                    if (count != '0) begin
                        state    <= SETUP;
                        rf_waddr <= head_addr;
                        rf_wdata <= head_data;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rf_mode <= RF_READ;
                end
            endcase
        end
    end

    // Walk from oldest to newest so the last match, the newest write, wins.
    always_comb begin
        rd_data = rf_rdata;
        rd_hit  = 1'b0;
        fwd_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_ptr + PW'(k);
            if (entry_valid[fwd_idx] && (entry_addr[fwd_idx] == rd_addr)) begin
                rd_hit  = 1'b1;
                rd_data = entry_data[fwd_idx];
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Bench for regfile_write_queue: table-driven vectors, hand sequences for
// back-pressure and mid-strobe reset, and a commit scoreboard.
module tb_regfile_write_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = 3;

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [AW-1:0] ra;
    logic [DW-1:0] rr;
    logic          x_mode;
    logic          x_hit;
    logic [DW-1:0] x_rd;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rf_mode;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic [DW-1:0] rd_data;
  logic          rd_hit;
  logic [CW-1:0] count;
  logic          empty;

  regfile_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rf_mode  (rf_mode),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .rd_addr  (rd_addr),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata),
    .rd_data  (rd_data),
    .rd_hit   (rd_hit),
    .count    (count),
    .empty    (empty)
  );

  // ---------------- model + scoreboard state ----------------
  int                  errors = 0;
  int                  checks = 0;
  int                  m_st;          // 0 idle, 1 setup, 2 strobe, 3 hold
  logic [AW-1:0]       m_wad;
  logic [DW-1:0]       m_wd;
  logic [AW+DW-1:0]    mq[$];         // entries pending in the queue
  logic [AW+DW-1:0]    exp_q[$];      // commits still expected on the rf port
  vec_t                vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_st  = 0;
    m_wad = '0;
    m_wd  = '0;
  endtask

  function automatic void fwd(input logic [AW-1:0] ra, output logic hit, output logic [DW-1:0] d);
    logic [AW+DW-1:0] e;
    hit = 1'b0;
    d   = rf_rdata;
    foreach (mq[i]) begin
      e = mq[i];
      if (e[AW+DW-1:DW] == ra) begin
        hit = 1'b1;
        d   = e[DW-1:0];
      end
    end
  endfunction

  function automatic vec_t mkv(logic v, logic [AW-1:0] a, logic [DW-1:0] d, logic [AW-1:0] ra,
                               logic [DW-1:0] rr, logic xm, logic xh, logic [DW-1:0] xrd);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.ra = ra; r.rr = rr;
    r.x_mode = xm; r.x_hit = xh; r.x_rd = xrd;
    return r;
  endfunction

  // ---------------- driver: one rising edge with current inputs ----------------
  task automatic step(output logic acc);
    int               n;
    int               nst;
    logic             pp;
    logic             h;
    logic [DW-1:0]    d;
    logic [AW+DW-1:0] e;
    n   = mq.size();
    acc = wr_valid && (n < DEPTH);
    pp  = (m_st == 2);
    case (m_st)
      0:       nst = (n > 0) ? 1 : 0;
      1:       nst = 2;
      2:       nst = 3;
      default: nst = (n > 0) ? 1 : 0;
    endcase
    if (nst == 1 && (m_st == 0 || m_st == 3)) begin
      e     = mq[0];
      m_wad = e[AW+DW-1:DW];
      m_wd  = e[DW-1:0];
    end
    @(posedge clk);
    #1;
    if (pp) void'(mq.pop_front());
    if (acc) begin
      mq.push_back({wr_addr, wr_data});
      exp_q.push_back({wr_addr, wr_data});
    end
    m_st = nst;
    chk("count",    32'(count),    32'(mq.size()));
    chk("empty",    32'(empty),    32'(mq.size() == 0 && m_st == 0));
    chk("wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
    chk("rf_mode",  32'(rf_mode),  32'(m_st == 2));
    chk("rf_waddr", 32'(rf_waddr), 32'(m_wad));
    chk("rf_wdata", rf_wdata,      m_wd);
    chk("rf_raddr", 32'(rf_raddr), 32'(rd_addr));
    fwd(rd_addr, h, d);
    chk("rd_hit",   32'(rd_hit),   32'(h));
    chk("rd_data",  rd_data,       d);
    // scoreboard: each observed strobe must match the oldest accepted write
    if (rf_mode === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL commit_spurious: got strobe addr %h required none at %0t", rf_waddr, $time);
      end else begin
        e = exp_q.pop_front();
        chk("commit_addr", 32'(rf_waddr), 32'(e[AW+DW-1:DW]));
        chk("commit_data", rf_wdata, e[DW-1:0]);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic          acc;
    logic          h;
    logic [DW-1:0] d;
    int            accepted;
    int            cycles;

    reset    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr  = '0;
    rf_rdata = '0;
    model_reset();

    // single write, forwarding window, duplicate address ordering
    vecs[0]  = mkv(1'b1, 5'd0, 32'h0919_1232, 5'd0, 32'h1111_0000, 1'b0, 1'b1, 32'h0919_1232);
    vecs[1]  = mkv(1'b0, 5'd0, 32'h0,         5'd0, 32'h1111_0000, 1'b0, 1'b1, 32'h0919_1232);
    vecs[2]  = mkv(1'b0, 5'd0, 32'h0,         5'd0, 32'h1111_0000, 1'b1, 1'b1, 32'h0919_1232);
    vecs[3]  = mkv(1'b0, 5'd0, 32'h0,         5'd0, 32'h1111_0000, 1'b0, 1'b0, 32'h1111_0000);
    vecs[4]  = mkv(1'b0, 5'd0, 32'h0,         5'd0, 32'h1111_0000, 1'b0, 1'b0, 32'h1111_0000);
    vecs[5]  = mkv(1'b1, 5'd1, 32'h0931_9232, 5'd1, 32'h0,         1'b0, 1'b1, 32'h0931_9232);
    vecs[6]  = mkv(1'b0, 5'd0, 32'h0,         5'd1, 32'h0,         1'b0, 1'b1, 32'h0931_9232);
    vecs[7]  = mkv(1'b0, 5'd0, 32'h0,         5'd1, 32'h0,         1'b1, 1'b1, 32'h0931_9232);
    vecs[8]  = mkv(1'b0, 5'd0, 32'h0,         5'd1, 32'h0,         1'b0, 1'b0, 32'h0);
    vecs[9]  = mkv(1'b0, 5'd0, 32'h0,         5'd1, 32'h0,         1'b0, 1'b0, 32'h0);
    vecs[10] = mkv(1'b1, 5'd2, 32'hA,         5'd2, 32'hDEAD,      1'b0, 1'b1, 32'hA);
    vecs[11] = mkv(1'b1, 5'd2, 32'hB,         5'd2, 32'hDEAD,      1'b0, 1'b1, 32'hB);
    vecs[12] = mkv(1'b0, 5'd0, 32'h0,         5'd2, 32'hDEAD,      1'b1, 1'b1, 32'hB);
    vecs[13] = mkv(1'b0, 5'd0, 32'h0,         5'd2, 32'hDEAD,      1'b0, 1'b1, 32'hB);
    vecs[14] = mkv(1'b0, 5'd0, 32'h0,         5'd2, 32'hDEAD,      1'b0, 1'b1, 32'hB);
    vecs[15] = mkv(1'b0, 5'd0, 32'h0,         5'd2, 32'hDEAD,      1'b1, 1'b1, 32'hB);
    vecs[16] = mkv(1'b0, 5'd0, 32'h0,         5'd2, 32'hDEAD,      1'b0, 1'b0, 32'hDEAD);
    vecs[17] = mkv(1'b0, 5'd0, 32'h0,         5'd2, 32'hDEAD,      1'b0, 1'b0, 32'hDEAD);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_mode",  32'(rf_mode),  32'h0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'h0);
    chk("rst_rf_wdata", rf_wdata,      32'h0);
    chk("rst_count",    32'(count),    32'h0);
    chk("rst_empty",    32'(empty),    32'h1);
    chk("rst_wr_ready", 32'(wr_ready), 32'h1);
    chk("rst_rd_hit",   32'(rd_hit),   32'h0);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      wr_valid = vecs[i].v;
      wr_addr  = vecs[i].a;
      wr_data  = vecs[i].d;
      rd_addr  = vecs[i].ra;
      rf_rdata = vecs[i].rr;
      #1;
      // a write is not visible before the edge that accepts it
      fwd(rd_addr, h, d);
      chk($sformatf("tbl%0d_pre_hit", i), 32'(rd_hit), 32'(h));
      step(acc);
      chk($sformatf("tbl%0d_mode", i), 32'(rf_mode), 32'(vecs[i].x_mode));
      chk($sformatf("tbl%0d_hit", i),  32'(rd_hit),  32'(vecs[i].x_hit));
      chk($sformatf("tbl%0d_rd", i),   rd_data,      vecs[i].x_rd);
    end
    wr_valid = 1'b0;

    // back-pressure: 7 writes with valid held; full after 4 pending
    accepted = 0;
    cycles   = 0;
    acc      = 1'b1;
    wr_valid = 1'b1;
    while (accepted < 7 && cycles < 40) begin
      if (acc) begin
        wr_addr = AW'($urandom_range(0, 7));
        wr_data = $urandom;
      end
      rd_addr  = AW'($urandom_range(0, 7));
      rf_rdata = $urandom;
      step(acc);
      if (acc) accepted++;
      cycles++;
    end
    wr_valid = 1'b0;
    chk("fill_accepted", 32'(accepted), 32'd7);
    chk("fill_cycles",   32'(cycles),   32'd11);

    cycles = 0;
    while ((mq.size() > 0 || m_st != 0) && cycles < 60) begin
      rd_addr = AW'($urandom_range(0, 7));
      step(acc);
      cycles++;
    end
    chk("drain_empty", 32'(empty), 32'h1);
    chk("drain_sb",    32'(exp_q.size()), 32'h0);

    // reset asserted in the middle of a strobe with 3 pending
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(10 + k);
      wr_data  = $urandom;
      step(acc);
    end
    wr_valid = 1'b0;
    chk("pre_rst_strobe", 32'(rf_mode), 32'h1);
    chk("pre_rst_count",  32'(count),   32'd3);
    rd_addr  = 5'd11;
    rf_rdata = 32'h0BAD_0BAD;
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_async_mode",   32'(rf_mode),  32'h0);
    chk("rst_async_count",  32'(count),    32'h0);
    chk("rst_async_empty",  32'(empty),    32'h1);
    chk("rst_async_ready",  32'(wr_ready), 32'h1);
    chk("rst_async_hit",    32'(rd_hit),   32'h0);
    chk("rst_async_rdata",  rd_data,       32'h0BAD_0BAD);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(acc);
    end
    chk("post_rst_sb", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
